// File: rtl/three.sv
// Registered 3-input equality/majority/parity with saturating run counter.
// Optional THREE_STATS_EN adds a saturating mismatch counter with sync clear.
module three #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             x,
   input  logic             y,
   input  logic             z,
   output logic             o,
   output logic             maj,
   output logic             par,
   output logic [2:0]       odd_mask,
   output logic [CNT_W-1:0] run_cnt,
   output logic             o_vld
`ifdef THREE_STATS_EN
   ,
   input  logic             stats_clr,
   output logic [CNT_W-1:0] mis_cnt
`endif
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic             sync1_q;
   logic             sync2_q;
   logic             rst_sync_n;

   logic             eq_d;
   logic             maj_d;
   logic             par_d;
   logic [2:0]       odd_d;
   logic [CNT_W-1:0] run_d;

   logic             o_q;
   logic             maj_q;
   logic             par_q;
   logic [2:0]       odd_q;
   logic [CNT_W-1:0] run_q;
   logic             vld_q;

   // Assert asynchronously, release two edges after rst_n rises
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= 1'b1;
         sync2_q <= sync1_q;
      end
   end

   assign rst_sync_n = sync2_q;

   always_comb begin
      eq_d  = (x & y & z) | ~(x | y | z);
      maj_d = (x & y) | (x & z) | (y & z);
      par_d = x ^ y ^ z;
      odd_d = {z, y, x} ^ {3{maj_d}};
      run_d = '0;
      if (eq_d) begin
         run_d = (run_q == CNT_MAX) ? run_q : run_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         o_q   <= 1'b0;
         maj_q <= 1'b0;
         par_q <= 1'b0;
         odd_q <= 3'b000;
         run_q <= '0;
         vld_q <= 1'b0;
      end else begin
         o_q   <= eq_d;
         maj_q <= maj_d;
         par_q <= par_d;
         odd_q <= odd_d;
         run_q <= run_d;
         vld_q <= 1'b1;
      end
   end

   assign o        = o_q;
   assign maj      = maj_q;
   assign par      = par_q;
   assign odd_mask = odd_q;
   assign run_cnt  = run_q;
   assign o_vld    = vld_q;

`ifdef THREE_STATS_EN
   logic [CNT_W-1:0] mis_d;
   logic [CNT_W-1:0] mis_q;

   always_comb begin
      mis_d = mis_q;
      if (stats_clr) begin
         mis_d = '0;
      end else if (!eq_d && mis_q != CNT_MAX) begin
         mis_d = mis_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         mis_q <= '0;
      end else begin
         mis_q <= mis_d;
      end
   end

   assign mis_cnt = mis_q;
`endif

endmodule

// File: tb/tb_three.sv
// Scoreboard bench for three: 8-bit and 2-bit counter instances share inputs.
// Expected results are queued at stimulus time and popped by a monitor.
module tb_three;

   logic       clk;
   logic       rst_n;
   logic       x, y, z;
   logic       stats_clr;

   logic       o_a, maj_a, par_a, vld_a;
   logic [2:0] odd_a;
   logic [7:0] run_a;
   logic       o_b, maj_b, par_b, vld_b;
   logic [2:0] odd_b;
   logic [1:0] run_b;
`ifdef THREE_STATS_EN
   logic [7:0] mis_a;
   logic [1:0] mis_b;
`endif

   three #(.CNT_W(8)) u_a (
      .clk(clk), .rst_n(rst_n), .x(x), .y(y), .z(z),
      .o(o_a), .maj(maj_a), .par(par_a), .odd_mask(odd_a),
      .run_cnt(run_a), .o_vld(vld_a)
`ifdef THREE_STATS_EN
      , .stats_clr(stats_clr), .mis_cnt(mis_a)
`endif
   );

   three #(.CNT_W(2)) u_b (
      .clk(clk), .rst_n(rst_n), .x(x), .y(y), .z(z),
      .o(o_b), .maj(maj_b), .par(par_b), .odd_mask(odd_b),
      .run_cnt(run_b), .o_vld(vld_b)
`ifdef THREE_STATS_EN
      , .stats_clr(stats_clr), .mis_cnt(mis_b)
`endif
   );

   typedef struct {
      logic [5:0] f;
      logic [7:0] r8;
      logic [1:0] r2;
      logic       mk;
      logic [7:0] m8;
      logic [1:0] m2;
   } exp_t;

   exp_t       q[$];
   logic [5:0] tab[8];
   int         n_cmp;
   int         n_err;
   int         run8, run2, mis8, mis2;
   logic       mis_known;
   logic       done;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // {z,y,x} -> {o,maj,par,odd_mask[2:0]}, hand-computed
   initial begin
      tab[0] = 6'b100_000;
      tab[1] = 6'b001_001;
      tab[2] = 6'b001_010;
      tab[3] = 6'b010_100;
      tab[4] = 6'b001_100;
      tab[5] = 6'b010_010;
      tab[6] = 6'b010_001;
      tab[7] = 6'b111_000;
   end

   task automatic apply(input logic [2:0] zyx, input logic clr);
      exp_t e;
      logic eq;
      @(negedge clk);
      x = zyx[0];
      y = zyx[1];
      z = zyx[2];
      stats_clr = clr;
      e.f = tab[zyx];
      eq = e.f[5];
      run8 = eq ? ((run8 == 255) ? 255 : run8 + 1) : 0;
      run2 = eq ? ((run2 == 3) ? 3 : run2 + 1) : 0;
      if (clr) begin
         mis8 = 0;
         mis2 = 0;
         mis_known = 1'b1;
      end else if (!eq) begin
         mis8 = (mis8 == 255) ? 255 : mis8 + 1;
         mis2 = (mis2 == 3) ? 3 : mis2 + 1;
      end
      e.r8 = 8'(run8);
      e.r2 = 2'(run2);
      e.mk = mis_known;
      e.m8 = 8'(mis8);
      e.m2 = 2'(mis2);
      q.push_back(e);
   endtask

   task automatic check_cleared(input string tag);
      chk({tag, "_o"}, 32'(o_a), 0);
      chk({tag, "_maj"}, 32'(maj_a), 0);
      chk({tag, "_par"}, 32'(par_a), 0);
      chk({tag, "_odd"}, 32'(odd_a), 0);
      chk({tag, "_run"}, 32'(run_a), 0);
      chk({tag, "_vld"}, 32'(vld_a), 0);
      chk({tag, "_run_b"}, 32'(run_b), 0);
      chk({tag, "_vld_b"}, 32'(vld_b), 0);
`ifdef THREE_STATS_EN
      chk({tag, "_mis"}, 32'(mis_a), 0);
`endif
   endtask

   task automatic wait_vld();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (vld_a) break;
      end
      chk("vld_rise", 32'(vld_a), 1);
      chk("vld_rise_b", 32'(vld_b), 1);
      run8 = 0;
      run2 = 0;
      mis_known = 1'b0;
   endtask

   always begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         if (!vld_a) begin
            chk("vld_missing", 32'(vld_a), 1);
         end else begin
            chk("o", 32'(o_a), 32'(e.f[5]));
            chk("maj", 32'(maj_a), 32'(e.f[4]));
            chk("par", 32'(par_a), 32'(e.f[3]));
            chk("odd_mask", 32'(odd_a), 32'(e.f[2:0]));
            chk("run_cnt", 32'(run_a), 32'(e.r8));
            chk("run_cnt_w2", 32'(run_b), 32'(e.r2));
            chk("odd_mask_w2", 32'(odd_b), 32'(e.f[2:0]));
`ifdef THREE_STATS_EN
            if (e.mk) begin
               chk("mis_cnt", 32'(mis_a), 32'(e.m8));
               chk("mis_cnt_w2", 32'(mis_b), 32'(e.m2));
            end
`endif
         end
      end
   end

   initial begin
      n_cmp = 0;
      n_err = 0;
      run8 = 0;
      run2 = 0;
      mis8 = 0;
      mis2 = 0;
      mis_known = 1'b0;
      done = 1'b0;
      rst_n = 1'b0;
      x = 1'b1;
      y = 1'b1;
      z = 1'b1;
      stats_clr = 1'b0;

      repeat (3) @(negedge clk);
      check_cleared("rst");

      x = 1'b1;
      y = 1'b0;
      z = 1'b0;
      rst_n = 1'b1;
      wait_vld();

      repeat (20) apply(3'b000, 1'b0);
      repeat (5) apply(3'b111, 1'b0);
      apply(3'b001, 1'b0);
      for (int i = 0; i < 8; i++) apply(3'(i), 1'b0);

      apply(3'b001, 1'b1);
      repeat (10) apply(3'b010, 1'b0);
      apply(3'b110, 1'b1);
      repeat (3) apply(3'b101, 1'b0);
      repeat (2) apply(3'b111, 1'b0);

      @(negedge clk);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check_cleared("async");
      @(negedge clk);
      x = 1'b1;
      y = 1'b0;
      z = 1'b0;
      stats_clr = 1'b0;
      #2;
      rst_n = 1'b1;
      #1;
      chk("vld_held_low", 32'(vld_a), 0);
      wait_vld();

      repeat (4) apply(3'b111, 1'b0);
      apply(3'b100, 1'b1);
      apply(3'b000, 1'b0);

      @(negedge clk);
      @(negedge clk);
      chk("queue_drained", 32'(q.size()), 0);
      done = 1'b1;
   end

   initial begin
      #20000;
      if (!done) begin
         n_cmp++;
         n_err++;
         $display("FAIL timeout: done=%0d expected 1", done);
      end
   end

   always @(posedge done or posedge clk) begin
      if (done || $time > 20000) begin
         $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                  n_cmp, n_err);
         $finish;
      end
   end

endmodule
